wght_load_ctrl: RTL and testbench
=================================

WGHT_LOAD_CTRL -- requirements
Module: wght_load_ctrl

Interface
REQ-001 Parameter NUM_FILTER, default 6: number of per-filter weight SRAMs read in parallel; sizing only.
REQ-002 Parameter RAM_DEPTH, default 5: words per weight SRAM, which is also the number of reads per load.
REQ-003 Parameter RAM_ADDRW, default 3: SRAM and register-bank address width; must satisfy 2**RAM_ADDRW >= RAM_DEPTH.
REQ-004 wld_clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 wld_rst  in  1  reset, asynchronous, active-high.
REQ-006 wld_start_i  in  1  load request, sampled each cycle; acted on only in IDLE.
REQ-007 wght_ack_i  in  1  consumer releases the loaded weights; acted on only in VALID.
REQ-008 ram_rd_en_o  out  1  read strobe to all NUM_FILTER SRAMs.
REQ-009 ram_rd_addr_o  out  RAM_ADDRW  shared SRAM read address.
REQ-010 reg_wr_en_o  out  1  write strobe to the weight register bank.
REQ-011 reg_wr_addr_o  out  RAM_ADDRW  register-bank word index, all filters written in parallel.
REQ-012 wld_busy_o  out  1  high in READ and DRAIN.
REQ-013 wld_done_o  out  1  one-cycle pulse when a load completes.
REQ-014 wght_valid_o  out  1  register bank holds a complete load, high in VALID.

Function
REQ-015 FSM states IDLE, READ, DRAIN, VALID; all outputs registered.
REQ-016 IDLE: wld_start_i=1 -> READ; otherwise stay.
REQ-017 READ: ram_rd_en_o=1 with ram_rd_addr_o stepping 0,1,...,RAM_DEPTH-1 on consecutive cycles, exactly RAM_DEPTH cycles, then -> DRAIN.
REQ-018 SRAM read latency is fixed at 1 cycle: reg_wr_en_o and reg_wr_addr_o equal ram_rd_en_o and ram_rd_addr_o delayed by one cycle.
REQ-019 DRAIN lasts 1 cycle; it covers the write of address RAM_DEPTH-1 and then moves to VALID.
REQ-020 wld_done_o=1 in the first VALID cycle only; wght_valid_o=1 for every VALID cycle.
REQ-021 VALID: wght_ack_i=1 -> IDLE; wght_valid_o falls on the next cycle.
REQ-022 Latency: with start sampled at edge k, ram_rd_en_o is high on cycles k+1..k+RAM_DEPTH and wld_done_o is high on cycle k+RAM_DEPTH+2.
REQ-023 wld_start_i outside IDLE is ignored and is not queued.
REQ-024 wght_ack_i outside VALID is ignored.
REQ-025 wght_ack_i and wld_start_i both high in VALID -> IDLE only; a new load needs a fresh start in IDLE.
REQ-026 The address counter clears to 0 on every entry to READ; it never wraps past RAM_DEPTH-1.
REQ-027 When ram_rd_en_o or reg_wr_en_o is 0, the matching address output holds 0.

Reset
REQ-028 wld_rst asserted, in any state, forces IDLE immediately and clears counter, state and all outputs to 0.
REQ-029 A reset during READ or DRAIN aborts the load; no further reg_wr_en_o pulse occurs and wght_valid_o stays 0.
REQ-030 After reset deasserts, the first cycle with wld_start_i=1 begins a full load from address 0.

Structure
REQ-031 The shared package wght_pkg holds the state enum typedef and the default NUM_FILTER, RAM_DEPTH and RAM_ADDRW constants.
REQ-032 One sub-module, upcounter, generates the address (load value 0, terminal count RAM_DEPTH-1); the 1-cycle write-side delay stage is inline.

Verification
REQ-033 Reset, then start pulse at cycle 0 -> rd addr 0..4 on cycles 1..5, wr addr 0..4 on cycles 2..6, done on cycle 7, valid from cycle 7.
REQ-034 Start held high through the whole load -> exactly one load of 5 reads; no second load begins before the ack.
REQ-035 In VALID, ack and start together -> IDLE next cycle, valid=0, no reads issued.
REQ-036 Reset asserted on cycle 3 of READ -> all outputs 0 in the same cycle, no writes afterwards, state IDLE.
REQ-037 Ack pulsed during READ -> ignored; done still fires on cycle 7 and valid stays high until a later ack.
REQ-038 RAM_DEPTH=8, RAM_ADDRW=3 build -> addresses 0..7 with no wrap, done on cycle 10.

Source files
------------

// File: rtl/wght_pkg.sv
// Shared definitions for the weight-load controller slice.
//   - default sizing constants for the controller and its address counter
//   - load-sequencer state encoding
package wght_pkg;

  localparam int unsigned WLD_NUM_FILTER = 6;
  localparam int unsigned WLD_RAM_DEPTH  = 5;
  localparam int unsigned WLD_RAM_ADDRW  = 3;

  typedef enum logic [1:0] {
    WLD_IDLE  = 2'd0,
    WLD_READ  = 2'd1,
    WLD_DRAIN = 2'd2,
    WLD_VALID = 2'd3
  } wld_state_e;

endpackage

// File: rtl/wght_load_ctrl_upcounter.sv
// upcounter: saturating address counter.
//   clk, rst : clock and asynchronous active-high reset
//   clr      : synchronous load of 0 (wins over en)
//   en       : advance by one; holds once TERM is reached (never wraps)
//   cnt      : current count
//   tc       : high while cnt equals TERM
module upcounter #(
  parameter int unsigned           WIDTH = 3,
  parameter logic [WIDTH-1:0]      TERM  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  assign tc = (cnt == TERM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/wght_load_ctrl.sv
// wght_load_ctrl: sequences one load of RAM_DEPTH words from NUM_FILTER
// parallel weight SRAMs into the weight register bank.
//   wld_clk, wld_rst : clock, asynchronous active-high reset
//   wld_start_i      : load request (honoured only when idle)
//   wght_ack_i       : consumer releases the loaded weights (only when valid)
//   ram_rd_en_o/ram_rd_addr_o : shared SRAM read strobe/address
//   reg_wr_en_o/reg_wr_addr_o : register-bank write strobe/word index,
//                               the read side delayed by the 1-cycle SRAM latency
//   wld_busy_o   : load in progress
//   wld_done_o   : one-cycle pulse on load completion
//   wght_valid_o : register bank holds a complete load
module wght_load_ctrl
  import wght_pkg::*;
#(
  parameter int unsigned NUM_FILTER = WLD_NUM_FILTER,
  parameter int unsigned RAM_DEPTH  = WLD_RAM_DEPTH,
  parameter int unsigned RAM_ADDRW  = WLD_RAM_ADDRW
) (
  input  logic                 wld_clk,
  input  logic                 wld_rst,
  input  logic                 wld_start_i,
  input  logic                 wght_ack_i,
  output logic                 ram_rd_en_o,
  output logic [RAM_ADDRW-1:0] ram_rd_addr_o,
  output logic                 reg_wr_en_o,
  output logic [RAM_ADDRW-1:0] reg_wr_addr_o,
  output logic                 wld_busy_o,
  output logic                 wld_done_o,
  output logic                 wght_valid_o
);

  localparam logic [RAM_ADDRW-1:0] LAST_ADDR = RAM_ADDRW'(RAM_DEPTH - 1);

  if (NUM_FILTER == 0 || RAM_DEPTH == 0 || (2 ** RAM_ADDRW) < RAM_DEPTH) begin : g_cfg_err
    $error("wght_load_ctrl: invalid NUM_FILTER/RAM_DEPTH/RAM_ADDRW combination");
  end

  wld_state_e           state;
  wld_state_e           state_nxt;

  logic                 cnt_clr;
  logic                 cnt_en;
  logic                 cnt_tc;
  logic [RAM_ADDRW-1:0] cnt;

  logic                 rd_en_nxt;
  logic                 busy_nxt;
  logic                 done_nxt;
  logic                 valid_nxt;

  // The counter doubles as the registered read-address output: it is held
  // at 0 whenever the next cycle is not a READ cycle, so the address is
  // 0 with the strobe low and restarts from 0 on every entry to READ.
  upcounter #(
    .WIDTH (RAM_ADDRW),
    .TERM  (LAST_ADDR)
  ) u_addr_cnt (
    .clk (wld_clk),
    .rst (wld_rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .cnt (cnt),
    .tc  (cnt_tc)
  );

  assign ram_rd_addr_o = cnt;

  // State register
  always_ff @(posedge wld_clk or posedge wld_rst) begin
    if (wld_rst) begin
      state <= WLD_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      WLD_IDLE:  if (wld_start_i) state_nxt = WLD_READ;
      WLD_READ:  if (cnt_tc)      state_nxt = WLD_DRAIN;
      WLD_DRAIN:                  state_nxt = WLD_VALID;
      WLD_VALID: if (wght_ack_i)  state_nxt = WLD_IDLE;
      default:                    state_nxt = WLD_IDLE;
    endcase
  end

  // Output logic: values computed from the next state so that every
  // output is a flop aligned with the state it describes.
  always_comb begin
    cnt_en    = (state == WLD_READ);
    cnt_clr   = !((state == WLD_READ) && (state_nxt == WLD_READ));
    rd_en_nxt = (state_nxt == WLD_READ);
    busy_nxt  = (state_nxt == WLD_READ) || (state_nxt == WLD_DRAIN);
    valid_nxt = (state_nxt == WLD_VALID);
    done_nxt  = (state_nxt == WLD_VALID) && (state != WLD_VALID);
  end

  // Output registers; the write side is the read side one cycle later.
  always_ff @(posedge wld_clk or posedge wld_rst) begin
    if (wld_rst) begin
      ram_rd_en_o   <= 1'b0;
      reg_wr_en_o   <= 1'b0;
      reg_wr_addr_o <= '0;
      wld_busy_o    <= 1'b0;
      wld_done_o    <= 1'b0;
      wght_valid_o  <= 1'b0;
    end else begin
      ram_rd_en_o   <= rd_en_nxt;
      reg_wr_en_o   <= ram_rd_en_o;
      reg_wr_addr_o <= ram_rd_addr_o;
      wld_busy_o    <= busy_nxt;
      wld_done_o    <= done_nxt;
      wght_valid_o  <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_wght_load_ctrl.sv
module tb_wght_load_ctrl;

  localparam int D0 = 5;
  localparam int D1 = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic ack = 1'b0;

  logic       rd_en0, wr_en0, busy0, done0, valid0;
  logic [2:0] rd_addr0, wr_addr0;
  logic       rd_en1, wr_en1, busy1, done1, valid1;
  logic [2:0] rd_addr1, wr_addr1;

  logic [10:0] obs [2];
  assign obs[0] = {rd_en0, rd_addr0, wr_en0, wr_addr0, busy0, done0, valid0};
  assign obs[1] = {rd_en1, rd_addr1, wr_en1, wr_addr1, busy1, done1, valid1};

  int checks = 0;
  int errors = 0;
  bit run_chk = 1'b0;

  always #5 clk = ~clk;

  wght_load_ctrl u_dut0 (
    .wld_clk       (clk),
    .wld_rst       (rst),
    .wld_start_i   (start),
    .wght_ack_i    (ack),
    .ram_rd_en_o   (rd_en0),
    .ram_rd_addr_o (rd_addr0),
    .reg_wr_en_o   (wr_en0),
    .reg_wr_addr_o (wr_addr0),
    .wld_busy_o    (busy0),
    .wld_done_o    (done0),
    .wght_valid_o  (valid0)
  );

  wght_load_ctrl #(
    .NUM_FILTER (6),
    .RAM_DEPTH  (D1),
    .RAM_ADDRW  (3)
  ) u_dut1 (
    .wld_clk       (clk),
    .wld_rst       (rst),
    .wld_start_i   (start),
    .wght_ack_i    (ack),
    .ram_rd_en_o   (rd_en1),
    .ram_rd_addr_o (rd_addr1),
    .reg_wr_en_o   (wr_en1),
    .reg_wr_addr_o (wr_addr1),
    .wld_busy_o    (busy1),
    .wld_done_o    (done1),
    .wght_valid_o  (valid1)
  );

  // Reference model: mt[i] is the cycle number within the current load
  // (cycle 1 = first read after start was taken), -1 when idle.
  int mt [2] = '{-1, -1};

  function automatic int depth_of(input int i);
    return (i == 0) ? D0 : D1;
  endfunction

  function automatic logic [10:0] expv(input int t, input int d);
    logic       re, we, bs, dn, vl;
    logic [2:0] ra, wa;
    re = (t >= 1) && (t <= d);
    ra = re ? 3'(t - 1) : 3'd0;
    we = (t >= 2) && (t <= d + 1);
    wa = we ? 3'(t - 2) : 3'd0;
    bs = (t >= 1) && (t <= d + 1);
    dn = (t == d + 2);
    vl = (t >= d + 2);
    return {re, ra, we, wa, bs, dn, vl};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mt[0] = -1;
      mt[1] = -1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        int d;
        d = depth_of(i);
        if (mt[i] < 0)           mt[i] = start ? 1 : -1;
        else if (mt[i] >= d + 2) mt[i] = ack ? -1 : ((mt[i] + 1 > d + 3) ? d + 3 : mt[i] + 1);
        else                     mt[i] = mt[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      for (int i = 0; i < 2; i++) begin
        logic [10:0] e;
        e = expv(mt[i], depth_of(i));
        checks++;
        if (obs[i] !== e) begin
          errors++;
          $display("FAIL model_cmp inst%0d t=%0d actual=%b required=%b (rd_en,rd_addr,wr_en,wr_addr,busy,done,valid)",
                   i, mt[i], obs[i], e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int rd_lit [1:8] = '{0, 1, 2, 3, 4, -1, -1, -1};
  int wr_lit [1:8] = '{-1, 0, 1, 2, 3, 4, -1, -1};

  initial begin
    int nrd;
    int nbad;
    #1 rst = 1'b1;
    run_chk = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_out0", 32'(obs[0]), 32'd0);
    chk("reset_out1", 32'(obs[1]), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single start pulse, ack pulsed during READ (ignored)
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n <= 8) begin
        chk($sformatf("lit_rd_en_c%0d", n), 32'(rd_en0), 32'(rd_lit[n] >= 0));
        chk($sformatf("lit_rd_addr_c%0d", n), 32'(rd_addr0), 32'((rd_lit[n] >= 0) ? rd_lit[n] : 0));
        chk($sformatf("lit_wr_en_c%0d", n), 32'(wr_en0), 32'(wr_lit[n] >= 0));
        chk($sformatf("lit_wr_addr_c%0d", n), 32'(wr_addr0), 32'((wr_lit[n] >= 0) ? wr_lit[n] : 0));
      end
      chk($sformatf("lit_done_c%0d", n), 32'(done0), 32'(n == 7));
      chk($sformatf("lit_valid_c%0d", n), 32'(valid0), 32'(n >= 7));
      chk($sformatf("lit_d8_done_c%0d", n), 32'(done1), 32'(n == 10));
      if (n >= 1 && n <= 8) chk($sformatf("lit_d8_rd_addr_c%0d", n), 32'(rd_addr1), 32'(n - 1));
      tick();
      ack = (n == 2);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    @(negedge clk);
    chk("ack_valid0", 32'(valid0), 32'd0);
    chk("ack_valid1", 32'(valid1), 32'd0);

    // Start held high across a whole load: exactly one load
    start = 1'b1;
    nrd = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rd_en0) nrd++;
      tick();
    end
    chk("hold_start_reads", 32'(nrd), 32'd5);
    // Ack and start together in VALID: back to idle, no new load
    ack = 1'b1;
    tick();
    ack = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("ack_start_valid0", 32'(valid0), 32'd0);
    chk("ack_start_rd_en0", 32'(rd_en0), 32'd0);
    nbad = 0;
    for (int n = 0; n < 4; n++) begin
      tick();
      @(negedge clk);
      if (rd_en0 || rd_en1) nbad++;
    end
    chk("ack_start_no_reads", 32'(nbad), 32'd0);

    // Reset in cycle 3 of READ
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_read_out0", 32'(obs[0]), 32'd0);
    chk("rst_read_out1", 32'(obs[1]), 32'd0);
    tick();
    rst = 1'b0;
    nbad = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (wr_en0 || wr_en1 || valid0 || valid1 || rd_en0) nbad++;
      tick();
    end
    chk("rst_read_no_writes", 32'(nbad), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom_range(0, 3) == 0);
      ack   = ($urandom_range(0, 3) == 0);
      rst   = ($urandom_range(0, 63) == 0);
      tick();
    end
    start = 1'b0;
    ack = 1'b0;
    rst = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
